bitscan_encoder: RTL and testbench

- Parametrised, sequential successor to the team's one-hot-to-binary encoder.
- Accepts an arbitrary multi-hot request vector over a valid/ready handshake and emits the binary index of every set bit, one per output beat.
- Scan order is selectable: LSB-first or MSB-first.
- Sits between request-collection logic (interrupt/pending registers, free-slot maps) and index-consuming logic such as table lookups and grant queues.

---
 rtl/bitscan_encoder_pkg.sv | 40 ++++
 rtl/bitscan_encoder_if.sv | 27 ++
 rtl/bitscan_encoder_prio_enc.sv | 26 ++
 rtl/bitscan_encoder.sv | 89 ++++++++
 tb/tb_bitscan_encoder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bitscan_encoder_pkg.sv
// Shared types and helper functions for the bit-scan encoder and its priority encoder.
// Functions work on a fixed MAX_LINES-wide vector; callers zero-extend narrower vectors.
package bitscan_encoder_pkg;

  localparam int MAX_LINES = 256;
  localparam int MAX_W     = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic logic [MAX_W:0] popcount(input logic [MAX_LINES-1:0] vec);
    logic [MAX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      cnt = cnt + {{MAX_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  function automatic logic [MAX_W-1:0] prio_lsb(input logic [MAX_LINES-1:0] vec);
    logic [MAX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[MAX_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic [MAX_W-1:0] prio_msb(input logic [MAX_LINES-1:0] vec);
    logic [MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (vec[i]) idx = i[MAX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/bitscan_encoder_if.sv
// Request-in / index-out bundle of the bit-scan encoder.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
// valid may drop before ready, payload is only sampled on the transfer edge.
interface bitscan_encoder_if #(
  parameter  int LINES = 16,
  localparam int WIDTH = $clog2(LINES)
);
  logic             in_valid;
  logic             in_ready;
  logic [LINES-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_idx;
  logic             out_last;
  logic             out_none;
  logic [WIDTH:0]   out_cnt;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, out_cnt
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, out_cnt
  );
endinterface

// File: rtl/bitscan_encoder_prio_enc.sv
// Combinational priority encoder: index of the lowest (or highest) set bit plus a
// flag that the vector has at most one bit set. LINES must not exceed MAX_LINES.
module prio_enc
  import bitscan_encoder_pkg::*;
#(
  parameter  int LINES     = 16,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int WIDTH     = $clog2(LINES)
) (
  input  logic [LINES-1:0] i_vec,
  output logic [WIDTH-1:0] o_idx,
  output logic             o_one_or_less
);

  logic [MAX_LINES-1:0] w_ext;

  always_comb begin
    w_ext              = '0;
    w_ext[LINES-1:0]   = i_vec;
  end

  assign o_idx         = MSB_FIRST ? WIDTH'(prio_msb(w_ext)) : WIDTH'(prio_lsb(w_ext));
  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  assign o_one_or_less = ((i_vec & (i_vec - LINES'(1))) == '0);

endmodule

// File: rtl/bitscan_encoder.sv
// Sequential multi-hot to binary encoder: accepts a request vector and emits the
// index of every set bit, one beat per cycle, in LSB-first or MSB-first order.
module bitscan_encoder
  import bitscan_encoder_pkg::*;
#(
  parameter  int LINES     = 16,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int WIDTH     = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                rst_n,
  bitscan_encoder_if.slave    bus,
  output state_t              o_state
);

  state_t               r_state, w_state_nxt;
  logic [LINES-1:0]     r_pend, w_pend_nxt, w_clr_mask;
  logic [WIDTH:0]       r_cnt, w_cnt_nxt;
  logic                 r_none, w_none_nxt;
  logic [WIDTH-1:0]     w_idx;
  logic                 w_one_or_less;
  logic                 w_out_valid, w_out_last, w_beat_done, w_in_ready, w_load;
  logic [MAX_LINES-1:0] w_in_ext;

  prio_enc #(
    .LINES     (LINES),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .i_vec         (r_pend),
    .o_idx         (w_idx),
    .o_one_or_less (w_one_or_less)
  );

  assign w_out_valid = (r_state == ST_SCAN);
  assign w_out_last  = w_out_valid & (r_none | w_one_or_less);
  assign w_beat_done = w_out_valid & bus.out_ready;
  // Last-beat handshake reopens the input in the same cycle so vectors can run back to back.
  assign w_in_ready  = rst_n & (~w_out_valid | (w_beat_done & w_out_last));
  assign w_load      = bus.in_valid & w_in_ready;
  assign w_clr_mask  = LINES'(1) << w_idx;

  always_comb begin
    w_in_ext            = '0;
    w_in_ext[LINES-1:0] = bus.in_vec;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_none_nxt  = r_none;
    if (w_load) begin
      w_state_nxt = ST_SCAN;
      w_pend_nxt  = bus.in_vec;
      w_cnt_nxt   = (WIDTH + 1)'(popcount(w_in_ext));
      w_none_nxt  = (bus.in_vec == '0);
    end else if (w_beat_done) begin
      if (w_out_last) begin
        w_state_nxt = ST_IDLE;
        w_pend_nxt  = '0;
      end else begin
        w_pend_nxt  = r_pend & ~w_clr_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_none  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_none  <= w_none_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_idx   = w_out_valid ? w_idx : '0;
  assign bus.out_last  = w_out_last;
  assign bus.out_none  = r_none;
  assign bus.out_cnt   = r_cnt;
  assign o_state       = r_state;

endmodule

// File: tb/tb_bitscan_encoder.sv
// Bench for bitscan_encoder: LSB-first and MSB-first instances share one stimulus stream;
// each has its own expected-beat queue built from the set bits of every accepted vector.
module tb_bitscan_encoder;
  import bitscan_encoder_pkg::*;

  localparam int LINES = 16;
  localparam int WIDTH = 4;
  localparam int W     = 2 * WIDTH + 3;  // {idx, last, none, cnt}

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic [LINES-1:0] in_vec    = '0;
  logic             out_ready = 1'b0;
  bit               rand_rdy  = 1'b0;

  bitscan_encoder_if #(.LINES(LINES)) if_lsb ();
  bitscan_encoder_if #(.LINES(LINES)) if_msb ();
  state_t st_lsb, st_msb;

  assign if_lsb.in_valid  = in_valid;
  assign if_lsb.in_vec    = in_vec;
  assign if_lsb.out_ready = out_ready;
  assign if_msb.in_valid  = in_valid;
  assign if_msb.in_vec    = in_vec;
  assign if_msb.out_ready = out_ready;

  bitscan_encoder #(.LINES(LINES), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_lsb), .o_state(st_lsb));
  bitscan_encoder #(.LINES(LINES), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_msb), .o_state(st_msb));

  // scoreboard
  logic [W-1:0] exp_lsb_q[$];
  logic [W-1:0] exp_msb_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] pack_beat(input int idx, input bit last, input bit none, input int cnt);
    return {idx[WIDTH-1:0], last, none, cnt[WIDTH:0]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the set bits of v, ascending for LSB-first, descending for MSB-first.
  task automatic push_expected(input logic [LINES-1:0] v);
    int set_q[$];
    int n;
    set_q = {};
    for (int i = 0; i < LINES; i++) if (v[i]) set_q.push_back(i);
    n = set_q.size();
    if (n == 0) begin
      exp_lsb_q.push_back(pack_beat(0, 1'b1, 1'b1, 0));
      exp_msb_q.push_back(pack_beat(0, 1'b1, 1'b1, 0));
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_lsb_q.push_back(pack_beat(set_q[k], k == n - 1, 1'b0, n));
        exp_msb_q.push_back(pack_beat(set_q[n - 1 - k], k == n - 1, 1'b0, n));
      end
    end
  endtask

  task automatic mon_one(input string tag, input int has, input logic [W-1:0] front,
                         input logic ov, input logic ir, input logic [W-1:0] got);
    check({tag, ".out_valid"}, W'(ov), W'(has != 0));
    check({tag, ".in_ready"}, W'(ir), W'(has == 0 || (out_ready && front[WIDTH+2])));
    if (ov && has != 0) check({tag, ".beat"}, got, front);
  endtask

  // monitor: checks every cycle, consumes a beat whenever the DUT transfers one
  always @(negedge clk) begin
    if (rst_n) begin
      mon_one("lsb", exp_lsb_q.size(), (exp_lsb_q.size() != 0) ? exp_lsb_q[0] : W'(0),
              if_lsb.out_valid, if_lsb.in_ready,
              {if_lsb.out_idx, if_lsb.out_last, if_lsb.out_none, if_lsb.out_cnt});
      mon_one("msb", exp_msb_q.size(), (exp_msb_q.size() != 0) ? exp_msb_q[0] : W'(0),
              if_msb.out_valid, if_msb.in_ready,
              {if_msb.out_idx, if_msb.out_last, if_msb.out_none, if_msb.out_cnt});
      if (out_ready && if_lsb.out_valid && exp_lsb_q.size() != 0) void'(exp_lsb_q.pop_front());
      if (out_ready && if_msb.out_valid && exp_msb_q.size() != 0) void'(exp_msb_q.pop_front());
    end
  end

  // driver tasks
  task automatic send(input logic [LINES-1:0] v);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_vec   = v;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = if_lsb.in_ready;
      @(posedge clk);
      guard++;
    end
    if (acc) push_expected(v);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: vector %h never accepted", v);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_lsb_q.size() != 0 || exp_msb_q.size() != 0) && g < 1000) begin
      @(posedge clk);
      g++;
    end
    check("drain", W'(exp_lsb_q.size() + exp_msb_q.size()), W'(0));
    #1;
  endtask

  initial begin
    out_ready = 1'b0;
    if (rand_rdy) out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINES-1:0] v;
    int kind, gap;

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", W'(if_lsb.out_valid), W'(0));
    check("rst.in_ready", W'(if_lsb.in_ready), W'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst.out_idx", W'(if_lsb.out_idx), W'(0));
    check("rst.out_last", W'(if_lsb.out_last), W'(0));
    check("rst.out_cnt", W'(if_lsb.out_cnt), W'(0));
    check("rst.out_none", W'(if_lsb.out_none), W'(0));
    check("rst.state_lsb", W'(st_lsb), W'(ST_IDLE));
    check("rst.state_msb", W'(st_msb), W'(ST_IDLE));
    @(posedge clk);
    #1;

    // scan order, both directions
    out_ready = 1'b1;
    send(16'h8421);
    wait_drain();

    // all-zero vector
    send(16'h0000);
    wait_drain();

    // backpressure: three stalled cycles on the first beat
    out_ready = 1'b0;
    send(16'h0003);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // back-to-back vectors with in_valid held
    send(16'h0001);
    send(16'h0010);
    wait_drain();

    // reset in the middle of a scan
    send(16'hFFFF);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_lsb_q.delete();
    exp_msb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst.out_valid_lsb", W'(if_lsb.out_valid), W'(0));
    check("midrst.out_valid_msb", W'(if_msb.out_valid), W'(0));
    check("midrst.in_ready", W'(if_lsb.in_ready), W'(0));
    check("midrst.out_cnt", W'(if_lsb.out_cnt), W'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // randomized vectors with random backpressure and input gaps
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       v = '0;
        1:       v = '1;
        2:       v = LINES'(1) << $urandom_range(0, LINES - 1);
        default: v = LINES'($urandom);
      endcase
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(v);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
